// File: rtl/j_sync_pkg.sv
// j_sync_pkg: shared defaults and channel slice helper for the j_sync register bank
package j_sync_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_STAGES = 1;
  function automatic int chan_off(input int i, input int w);
    return i * w;
  endfunction
endpackage

// File: rtl/j_sync_chan.sv
// j_sync_chan: one load-enable channel with retiming pipeline, change and pending status
module j_sync_chan import j_sync_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             stb,
  input  logic [WIDTH-1:0] d,
  input  logic             ld,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             chg,
  output logic             pend
);
  logic [STAGES-1:0][WIDTH-1:0] s, nxt;
  logic pend_nxt;
  always_comb begin
    nxt = s;
    nxt[0] = ld ? d : s[0];
    for (int k = 1; k < STAGES; k++) nxt[k] = s[k-1];
    pend_nxt = 1'b0;
    for (int k = 0; k < STAGES - 1; k++) pend_nxt = pend_nxt | (nxt[k] != nxt[STAGES-1]);
  end
  // qb is registered from the next value so it never lags q
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      s <= {STAGES{RESET_VAL}};
      qb <= ~RESET_VAL;
      chg <= 1'b0;
      pend <= 1'b0;
    end else begin
      chg <= stb && (nxt[STAGES-1] != s[STAGES-1]);
      if (stb) begin
        s <= nxt;
        qb <= ~nxt[STAGES-1];
        pend <= pend_nxt;
      end
    end
  end
  assign q = s[STAGES-1];
endmodule

// File: rtl/j_sync_bank.sv
// j_sync_bank: multi-channel load-enable register bank clocked by an edge-detected emulated clock
module j_sync_bank import j_sync_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int STAGES = DEF_STAGES,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      sys_clk,
  input  logic                      reset,
  input  logic                      clk,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [CHANNELS-1:0]       ld,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS*WIDTH-1:0] qb,
  output logic [CHANNELS-1:0]       chg,
  output logic [CHANNELS-1:0]       pend
);
  logic clk_d, stb;
  // clk_d resets high so a clk already high at release is not a strobe
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) clk_d <= 1'b1;
    else clk_d <= clk;
  end
  assign stb = clk & ~clk_d;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    j_sync_chan #(.WIDTH(WIDTH), .STAGES(STAGES), .RESET_VAL(RESET_VAL)) u_chan (
      .sys_clk(sys_clk),
      .reset(reset),
      .stb(stb),
      .d(d[chan_off(c, WIDTH) +: WIDTH]),
      .ld(ld[c]),
      .q(q[chan_off(c, WIDTH) +: WIDTH]),
      .qb(qb[chan_off(c, WIDTH) +: WIDTH]),
      .chg(chg[c]),
      .pend(pend[c])
    );
  end
endmodule

// File: doc/j_sync_bank.md
# j_sync_bank

Parametrised multi-channel load-enable register bank with an optional retiming pipeline. It generalises the single-bit load-enable flip-flop used throughout the Jerry netlists. Width, channel count and pipeline depth are set by parameters, and each channel adds change-detect and pending status. The emulated netlist clock `clk` is edge-detected in the `sys_clk` domain, so the bank drops into converted netlist logic wherever several `fd1e`-style holding registers share one emulated clock.

## Interface
Parameters:
- `WIDTH`, 8: bits per channel (≥1).
- `CHANNELS`, 4: number of independent channels (≥1).
- `STAGES`, 1: capture-pipeline depth in strobes (≥1). With 1, each channel behaves exactly as a single load-enable flip-flop.
- `RESET_VAL`, 0: WIDTH-bit value loaded into every stage of every channel on reset.

Ports:
- `sys_clk`  in  1: single system clock. All state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `clk`  in  1: emulated netlist clock, sampled on `sys_clk`. Its 0→1 transition forms the capture strobe.
- `d`  in  CHANNELS*WIDTH: load data, channel i at bits [i*WIDTH +: WIDTH].
- `ld`  in  CHANNELS: per-channel load enable, sampled on a strobe.
- `q`  out  CHANNELS*WIDTH: registered channel outputs.
- `qb`  out  CHANNELS*WIDTH: bitwise inverse of `q`, registered (not derived from `q` combinationally).
- `chg`  out  CHANNELS: one-cycle pulse when a channel's `q` changes value.
- `pend`  out  CHANNELS: channel has a loaded value still in flight that differs from `q` (always 0 when STAGES=1).

## Operation
- Strobe detect: register `clk_d` holds `clk` as sampled at the previous `sys_clk` edge. A strobe occurs at an edge where `clk`=1 and `clk_d`=0. One strobe is shared by all channels.
- Per channel, pipeline s[0..STAGES-1], with `q` = s[STAGES-1]. At a strobe edge:
  - s[0] ← `ld[i]` ? `d[i]` : s[0].
  - s[k] ← s[k-1] for k≥1.
  - For STAGES=1 this reduces to q ← ld ? d : q, which is the fd1e te/ti behaviour.
- Between strobes, all stages hold. `ld` and `d` are ignored off-strobe.
- `chg[i]` ← strobe AND (next `q` ≠ current `q`). On every other edge it clears to 0.
- `pend[i]` = 1 when any stage s[0..STAGES-2] differs from `q`. Registered, updated on the same edge as the stages.
- Channels are fully independent apart from the shared strobe.

## Timing
- Reset values:
  - Every stage, `q` = RESET_VAL; `qb` = ~RESET_VAL; `chg` = 0; `pend` = 0.
  - `clk_d` = 1, so if `clk` is high when reset releases it gives no strobe; the first strobe needs a 0→1 transition after reset.
- Latency: `d` captured at strobe edge n appears on `q` after strobe edge n+STAGES−1. STAGES=1 gives `q` updated at the capturing edge itself.
- `chg` is high for exactly one `sys_clk` cycle, the cycle after the edge where `q` changed. Two strobes can never occur on consecutive edges, so `chg` can never be high for two consecutive cycles.
- `ld`=1 with `d` equal to the current s[0]: the stages still shift. `chg` is raised only if `q` actually changes.
- `clk` held high or held low: no strobes, and all outputs hold indefinitely.
- Reset asserted mid-pipeline: in-flight values are discarded and outputs go to reset values immediately (asynchronous). After release, the first strobe behaves as after power-up.
- Glitch-free `clk` required: one `sys_clk` sample per level is sufficient. A `clk` pulse narrower than a `sys_clk` period may be missed, and that is accepted behaviour.

## Structure
- Package `j_sync_pkg`: default parameter constants, plus a function for channel slice offset (i*WIDTH).
- Sub-module `j_sync_chan` (WIDTH, STAGES, RESET_VAL): one channel's pipeline, `q`/`qb`/`chg`/`pend` logic, driven by the shared strobe.
- Top level holds the `clk_d` strobe detector and a generate loop of CHANNELS × `j_sync_chan`.

## Test plan
- Reset with `clk`=1, then release with `clk` held at 1 for 10 cycles → `q`=RESET_VAL, `qb`=~RESET_VAL, `chg`=0, `pend`=0 throughout.
- STAGES=1, WIDTH=8, channel 2: `d`=0xA5, `ld`=0b0100, one 0→1 on `clk` → q[2]=0xA5 after that edge; `chg`=0b0100 for exactly one cycle; other channels unchanged.
- STAGES=3: load 0x3C at strobe 1, `ld`=0 on strobes 2 and 3 → `pend`=1 after strobes 1 and 2; `q`=0x3C and `chg` pulse after strobe 3; `pend`=0 after that.
- Reload same value: `q`=0x11, strobe with `ld`=1, `d`=0x11 → `q`=0x11, `chg` stays 0.
- `ld`=1 with `d` toggling while `clk` is static for 20 cycles → no change on any output.
- Reset asserted between strobes 1 and 2 of a STAGES=3 load of 0x7F → `q`=RESET_VAL and `pend`=0 at once; three later strobes with `ld`=0 never show 0x7F on `q`.
